// File: rtl/vga_axil_slave_regs.sv
`default_nettype none
// ============================================================================
// Module      : vga_axil_slave_regs
// Description : AXI4-Lite slave register bank holding the VGA timing/config
//               words. Optional byte-lane write strobes via VGA_AXIL_WSTRB_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module vga_axil_slave_regs #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 8,
    parameter int NUM_REGS = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [ADDR_W-1:0]            awaddr,
    input  logic                         awvalid,
    output logic                         awready,
    input  logic [DATA_W-1:0]            wdata,
`ifdef VGA_AXIL_WSTRB_EN
    input  logic [DATA_W/8-1:0]          wstrb,
`endif
    input  logic                         wvalid,
    output logic                         wready,
    output logic [1:0]                   bresp,
    output logic                         bvalid,
    input  logic                         bready,
    input  logic [ADDR_W-1:0]            araddr,
    input  logic                         arvalid,
    output logic                         arready,
    output logic [DATA_W-1:0]            rdata,
    output logic [1:0]                   rresp,
    output logic                         rvalid,
    input  logic                         rready,
    output logic [NUM_REGS*DATA_W-1:0]   regs_o,
    output logic [NUM_REGS-1:0]          wr_pulse_o
);

    localparam int         c_IDX_W       = ADDR_W - 2;
    localparam int         c_NBYTES      = DATA_W / 8;
    localparam logic [1:0] c_RESP_OKAY   = 2'b00;
    localparam logic [1:0] c_RESP_SLVERR = 2'b10;

    typedef enum logic [0:0] {WR_IDLE = 1'b0, WR_RESP = 1'b1} wr_state_t;
    typedef enum logic [0:0] {RD_IDLE = 1'b0, RD_RESP = 1'b1} rd_state_t;

    wr_state_t              r_wr_state, w_wr_next;
    rd_state_t              r_rd_state, w_rd_next;
    logic                   w_wr_fire, w_rd_fire;
    logic [c_IDX_W-1:0]     w_wr_idx, w_rd_idx;
    logic [NUM_REGS-1:0]    w_wr_hit;
    logic                   w_wr_in_range, w_rd_in_range;
    logic [DATA_W-1:0]      w_rd_word;
    logic [c_NBYTES-1:0]    w_strb;
    logic [DATA_W-1:0]      r_regs [NUM_REGS];
    logic [NUM_REGS-1:0]    r_wr_pulse;
    logic [1:0]             r_bresp, r_rresp;
    logic [DATA_W-1:0]      r_rdata;
    logic                   w_unused;

`ifdef VGA_AXIL_WSTRB_EN
    assign w_strb = wstrb;
`else
    assign w_strb = '1;
`endif

    // Byte offset bits carry no meaning for word-wide registers.
    assign w_unused = ^{awaddr[1:0], araddr[1:0]};
    assign w_wr_idx = awaddr[ADDR_W-1:2];
    assign w_rd_idx = araddr[ADDR_W-1:2];

    // ---------------- write engine ----------------
    always_ff @(posedge clk) begin
        if (rst) r_wr_state <= WR_IDLE;
        else     r_wr_state <= w_wr_next;
    end

    always_comb begin
        w_wr_next = r_wr_state;
        awready   = 1'b0;
        wready    = 1'b0;
        w_wr_fire = 1'b0;
        case (r_wr_state)
            WR_IDLE: begin
                w_wr_fire = awvalid && wvalid;
                awready   = w_wr_fire;
                wready    = w_wr_fire;
                if (w_wr_fire) w_wr_next = WR_RESP;
            end
            WR_RESP: if (bready) w_wr_next = WR_IDLE;
            default: w_wr_next = WR_IDLE;
        endcase
    end

    // One-hot decode; indices at or beyond NUM_REGS match nothing and get SLVERR.
    always_comb begin
        w_wr_hit = '0;
        for (int i = 0; i < NUM_REGS; i++)
            w_wr_hit[i] = (int'(w_wr_idx) == i);
    end
    assign w_wr_in_range = |w_wr_hit;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_bresp    <= c_RESP_OKAY;
            r_wr_pulse <= '0;
            for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
        end else begin
            r_wr_pulse <= w_wr_fire ? w_wr_hit : '0;
            if (w_wr_fire) r_bresp <= w_wr_in_range ? c_RESP_OKAY : c_RESP_SLVERR;
            for (int i = 0; i < NUM_REGS; i++)
                for (int b = 0; b < c_NBYTES; b++)
                    if (w_wr_fire && w_wr_hit[i] && w_strb[b])
                        r_regs[i][b*8 +: 8] <= wdata[b*8 +: 8];
        end
    end

    assign bvalid     = (r_wr_state == WR_RESP);
    assign bresp      = r_bresp;
    assign wr_pulse_o = r_wr_pulse;

    // ---------------- read engine ----------------
    always_ff @(posedge clk) begin
        if (rst) r_rd_state <= RD_IDLE;
        else     r_rd_state <= w_rd_next;
    end

    always_comb begin
        w_rd_next = r_rd_state;
        arready   = 1'b0;
        w_rd_fire = 1'b0;
        case (r_rd_state)
            RD_IDLE: begin
                arready   = 1'b1;
                w_rd_fire = arvalid;
                if (arvalid) w_rd_next = RD_RESP;
            end
            RD_RESP: if (rready) w_rd_next = RD_IDLE;
            default: w_rd_next = RD_IDLE;
        endcase
    end

    // Reads sample the pre-edge register value, so a same-cycle write is not visible.
    always_comb begin
        w_rd_word     = '0;
        w_rd_in_range = 1'b0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (int'(w_rd_idx) == i) begin
                w_rd_word     = r_regs[i];
                w_rd_in_range = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rdata <= '0;
            r_rresp <= c_RESP_OKAY;
        end else if (w_rd_fire) begin
            r_rdata <= w_rd_word;
            r_rresp <= w_rd_in_range ? c_RESP_OKAY : c_RESP_SLVERR;
        end
    end

    assign rvalid = (r_rd_state == RD_RESP);
    assign rdata  = r_rdata;
    assign rresp  = r_rresp;

    generate
        for (genvar i = 0; i < NUM_REGS; i++) begin : g_regs_o
            assign regs_o[i*DATA_W +: DATA_W] = r_regs[i];
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_vga_axil_slave_regs.sv
`default_nettype none
// ============================================================================
// Module      : tb_vga_axil_slave_regs
// Description : Directed, table-driven bench for vga_axil_slave_regs.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vga_axil_slave_regs;

    localparam logic [1:0] c_OKAY   = 2'b00;
    localparam logic [1:0] c_SLVERR = 2'b10;

    logic         clk = 1'b0;
    logic         rst;
    logic [7:0]   awaddr;
    logic         awvalid;
    logic         awready;
    logic [31:0]  wdata;
    logic [3:0]   wstrb;
    logic         wvalid;
    logic         wready;
    logic [1:0]   bresp;
    logic         bvalid;
    logic         bready;
    logic [7:0]   araddr;
    logic         arvalid;
    logic         arready;
    logic [31:0]  rdata;
    logic [1:0]   rresp;
    logic         rvalid;
    logic         rready;
    logic [127:0] regs_o;
    logic [3:0]   wr_pulse_o;

    int n_checks = 0;
    int n_fail   = 0;

    vga_axil_slave_regs dut (
        .clk        (clk),
        .rst        (rst),
        .awaddr     (awaddr),
        .awvalid    (awvalid),
        .awready    (awready),
        .wdata      (wdata),
`ifdef VGA_AXIL_WSTRB_EN
        .wstrb      (wstrb),
`endif
        .wvalid     (wvalid),
        .wready     (wready),
        .bresp      (bresp),
        .bvalid     (bvalid),
        .bready     (bready),
        .araddr     (araddr),
        .arvalid    (arvalid),
        .arready    (arready),
        .rdata      (rdata),
        .rresp      (rresp),
        .rvalid     (rvalid),
        .rready     (rready),
        .regs_o     (regs_o),
        .wr_pulse_o (wr_pulse_o)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Returns at handshake edge + 1.
    task automatic do_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s);
        bit ok = 1'b0;
        awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (awready && wready) begin ok = 1'b1; break; end
        end
        @(posedge clk); #1;
        awvalid = 1'b0; wvalid = 1'b0;
        chk("aw_w_handshake", {127'd0, ok}, 128'd1);
    endtask

    task automatic do_read(input logic [7:0] a);
        bit ok = 1'b0;
        araddr = a; arvalid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (arready) begin ok = 1'b1; break; end
        end
        @(posedge clk); #1;
        arvalid = 1'b0;
        chk("ar_handshake", {127'd0, ok}, 128'd1);
    endtask

    typedef struct {
        bit         is_wr;
        logic [7:0]  addr;
        logic [31:0] data;
        logic [1:0]  resp;
        logic [31:0] rdat;
        logic [3:0]  pulse;
    } vec_t;

    vec_t vecs[12];

    initial begin
        vecs[0]  = '{1'b1, 8'h04, 32'hDEADBEEF, c_OKAY,   32'h0,        4'b0010};
        vecs[1]  = '{1'b0, 8'h04, 32'h0,        c_OKAY,   32'hDEADBEEF, 4'b0000};
        vecs[2]  = '{1'b1, 8'h40, 32'h12345678, c_SLVERR, 32'h0,        4'b0000};
        vecs[3]  = '{1'b0, 8'h40, 32'h0,        c_SLVERR, 32'h0,        4'b0000};
        vecs[4]  = '{1'b1, 8'h0C, 32'hCAFEF00D, c_OKAY,   32'h0,        4'b1000};
        vecs[5]  = '{1'b1, 8'h03, 32'h01020304, c_OKAY,   32'h0,        4'b0001};
        vecs[6]  = '{1'b0, 8'h00, 32'h0,        c_OKAY,   32'h01020304, 4'b0000};
        vecs[7]  = '{1'b0, 8'h0E, 32'h0,        c_OKAY,   32'hCAFEF00D, 4'b0000};
        vecs[8]  = '{1'b0, 8'h10, 32'h0,        c_SLVERR, 32'h0,        4'b0000};
        vecs[9]  = '{1'b0, 8'hFC, 32'h0,        c_SLVERR, 32'h0,        4'b0000};
        vecs[10] = '{1'b1, 8'hFC, 32'h55555555, c_SLVERR, 32'h0,        4'b0000};
        vecs[11] = '{1'b0, 8'h08, 32'h0,        c_OKAY,   32'h0,        4'b0000};

        rst = 1'b1; awaddr = '0; awvalid = 1'b0; wdata = '0; wstrb = 4'hF; wvalid = 1'b0;
        bready = 1'b1; araddr = '0; arvalid = 1'b0; rready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        chk("reset_bvalid",  {127'd0, bvalid}, 128'd0);
        chk("reset_rvalid",  {127'd0, rvalid}, 128'd0);
        chk("reset_regs",    regs_o, 128'd0);
        chk("reset_pulse",   {124'd0, wr_pulse_o}, 128'd0);
        chk("reset_rdata",   {96'd0, rdata}, 128'd0);
        chk("reset_arready", {127'd0, arready}, 128'd1);
        chk("reset_awready", {127'd0, awready}, 128'd0);

        // Table-driven transactions
        for (int v = 0; v < 12; v++) begin
            if (vecs[v].is_wr) begin
                do_write(vecs[v].addr, vecs[v].data, 4'hF);
                chk("wr_bvalid", {127'd0, bvalid}, 128'd1);
                chk("wr_bresp",  {126'd0, bresp}, {126'd0, vecs[v].resp});
                chk("wr_pulse",  {124'd0, wr_pulse_o}, {124'd0, vecs[v].pulse});
                @(posedge clk); #1;
                chk("wr_bvalid_clr", {127'd0, bvalid}, 128'd0);
                chk("wr_pulse_clr",  {124'd0, wr_pulse_o}, 128'd0);
            end else begin
                do_read(vecs[v].addr);
                chk("rd_rvalid", {127'd0, rvalid}, 128'd1);
                chk("rd_rresp",  {126'd0, rresp}, {126'd0, vecs[v].resp});
                chk("rd_rdata",  {96'd0, rdata}, {96'd0, vecs[v].rdat});
                @(posedge clk); #1;
                chk("rd_rvalid_clr", {127'd0, rvalid}, 128'd0);
            end
        end
        chk("regs_after_table", regs_o, {32'hCAFEF00D, 32'h0, 32'hDEADBEEF, 32'h01020304});

        // Write backpressure; read engine keeps working meanwhile
        bready = 1'b0;
        do_write(8'h08, 32'h22, 4'hF);
        awaddr = 8'h0C; wdata = 32'h99; awvalid = 1'b1; wvalid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("bp_awready", {127'd0, awready}, 128'd0);
            chk("bp_bvalid",  {127'd0, bvalid}, 128'd1);
            chk("bp_bresp",   {126'd0, bresp}, {126'd0, c_OKAY});
        end
        awvalid = 1'b0; wvalid = 1'b0;
        do_read(8'h08);
        chk("bp_indep_rdata", {96'd0, rdata}, 128'h22);
        chk("bp_still_bvalid", {127'd0, bvalid}, 128'd1);
        bready = 1'b1;
        @(posedge clk); #1;
        chk("bp_bvalid_clr", {127'd0, bvalid}, 128'd0);
        chk("bp_no_extra_wr", {96'd0, regs_o[127:96]}, 128'hCAFEF00D);

        // Read backpressure
        rready = 1'b0;
        do_read(8'h04);
        araddr = 8'h00; arvalid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("rbp_arready", {127'd0, arready}, 128'd0);
            chk("rbp_rvalid",  {127'd0, rvalid}, 128'd1);
            chk("rbp_rdata",   {96'd0, rdata}, 128'hDEADBEEF);
            chk("rbp_rresp",   {126'd0, rresp}, {126'd0, c_OKAY});
        end
        arvalid = 1'b0;
        rready = 1'b1;
        @(posedge clk); #1;
        chk("rbp_rvalid_clr", {127'd0, rvalid}, 128'd0);

        // Same-cycle read and write of one register
        awaddr = 8'h08; wdata = 32'h11; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
        araddr = 8'h08; arvalid = 1'b1;
        @(negedge clk);
        chk("same_ready", {126'd0, awready, arready}, 128'd3);
        @(posedge clk); #1;
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        chk("same_old_rdata", {96'd0, rdata}, 128'h22);
        chk("same_bvalid", {127'd0, bvalid}, 128'd1);
        @(posedge clk); #1;
        do_read(8'h08);
        chk("same_new_rdata", {96'd0, rdata}, 128'h11);
        @(posedge clk); #1;

`ifdef VGA_AXIL_WSTRB_EN
        do_write(8'h00, 32'hAABBCCDD, 4'hF);
        @(posedge clk); #1;
        do_write(8'h00, 32'h11223344, 4'b0101);
        chk("strb_bresp", {126'd0, bresp}, {126'd0, c_OKAY});
        @(posedge clk); #1;
        chk("strb_reg0", {96'd0, regs_o[31:0]}, 128'hAA22CC44);
        do_write(8'h00, 32'hFFFFFFFF, 4'b0000);
        chk("strb0_bresp", {126'd0, bresp}, {126'd0, c_OKAY});
        chk("strb0_pulse", {124'd0, wr_pulse_o}, 128'b0001);
        @(posedge clk); #1;
        do_read(8'h00);
        chk("strb0_rdata", {96'd0, rdata}, 128'hAA22CC44);
        @(posedge clk); #1;
`endif

        // Reset while a read response is stalled
        rready = 1'b0;
        do_read(8'h0C);
        chk("rst_pre_rvalid", {127'd0, rvalid}, 128'd1);
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        chk("rst_rvalid",  {127'd0, rvalid}, 128'd0);
        chk("rst_regs",    regs_o, 128'd0);
        chk("rst_arready", {127'd0, arready}, 128'd1);
        chk("rst_rdata",   {96'd0, rdata}, 128'd0);
        rready = 1'b1;
        @(posedge clk); #1;
        chk("rst_no_replay", {127'd0, rvalid}, 128'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
